mimo_sym_packer: RTL and testbench

MIMO_SYM_PACKER -- requirements
Module: mimo_sym_packer

---
 rtl/mimo_pkg.sv | 20 ++
 rtl/mimo_byte_fifo.sv | 66 ++++++
 rtl/mimo_sym_packer.sv | 133 +++++++++++++
 tb/tb_mimo_sym_packer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mimo_pkg.sv
// Shared types and constants for the MIMO QPSK symbol packer.
package mimo_pkg;

    localparam int unsigned DEMOD_W            = 3;
    localparam int unsigned NIBBLE_W           = 4;
    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    // Packer FSM: EMPTY holds nothing, HALF holds the high nibble of the next byte.
    typedef logic [0:0] pack_state_t;
    localparam pack_state_t ST_EMPTY = 1'b0;
    localparam pack_state_t ST_HALF  = 1'b1;

    // One queued output byte with its end-of-frame flag.
    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } byte_entry_t;

endpackage

// File: rtl/mimo_byte_fifo.sv
// First-word-fall-through byte FIFO; head entry is visible whenever not_empty is high.
module mimo_byte_fifo
    import mimo_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  byte_entry_t push_entry,
    input  logic        pop,
    output byte_entry_t head,
    output logic        not_empty,
    output logic        full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    byte_entry_t       mem_q [DEPTH];
    byte_entry_t       mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrapping mod DEPTH) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push_ok  = push && !full;
        pop_ok   = pop && not_empty;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // State registers; reset discards every queued entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mimo_sym_packer.sv
// Packs pairs of QPSK indices (two streams) into bytes, two pairs per byte.
// Optional statistics outputs byte_cnt/stall_cnt exist only when
// MIMO_PACK_STATS_EN is defined.
module mimo_sym_packer
    import mimo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DEMOD_W-1:0] demod_1,
    input  logic [DEMOD_W-1:0] demod_2,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [BYTE_W-1:0]  byte_data,
    output logic               byte_valid,
    output logic               byte_last,
    input  logic               byte_ready,
    output logic               sym_err
`ifdef MIMO_PACK_STATS_EN
    ,
    output logic [15:0]        byte_cnt,
    output logic [15:0]        stall_cnt
`endif
);

    pack_state_t         state_q,   state_d;
    logic [NIBBLE_W-1:0] hold_q,    hold_d;
    logic                sym_err_q, sym_err_d;
    logic [NIBBLE_W-1:0] nibble;
    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_full;
    byte_entry_t         push_entry;
    byte_entry_t         head;

    // Handshakes; in_ready deliberately ignores a same-cycle pop.
    assign in_ready = !rst && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign pop      = byte_valid && byte_ready;
    assign nibble   = {demod_1[1:0], demod_2[1:0]};

    assign byte_data = head.data;
    assign byte_last = head.last;
    assign sym_err   = sym_err_q;

    // Packing FSM: decide hold vs push for each accepted pair.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        sym_err_d  = sym_err_q;
        push       = 1'b0;
        push_entry = '0;
        if (accept) begin
            if (demod_1[2] || demod_2[2]) begin
                sym_err_d = 1'b1;
            end
            if (state_q == ST_EMPTY) begin
                if (in_last) begin
                    push            = 1'b1;
                    push_entry.last = 1'b1;
                    push_entry.data = {nibble, NIBBLE_W'(0)};
                end else begin
                    hold_d  = nibble;
                    state_d = ST_HALF;
                end
            end else begin
                push            = 1'b1;
                push_entry.last = in_last;
                push_entry.data = {hold_q, nibble};
                hold_d          = '0;
                state_d         = ST_EMPTY;
            end
        end
    end

    // FSM, held nibble and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            hold_q    <= '0;
            sym_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            sym_err_q <= sym_err_d;
        end
    end

    mimo_byte_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .not_empty  (byte_valid),
        .full       (fifo_full)
    );

`ifdef MIMO_PACK_STATS_EN
    logic [15:0] byte_cnt_q,  byte_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign byte_cnt  = byte_cnt_q;
    assign stall_cnt = stall_cnt_q;

    // Popped-byte counter wraps; stall counter saturates.
    always_comb begin
        byte_cnt_d  = byte_cnt_q + 16'(pop);
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mimo_sym_packer.sv
// Directed bench for mimo_sym_packer; stats checks follow MIMO_PACK_STATS_EN.
module tb_mimo_sym_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  demod_1;
    logic [2:0]  demod_2;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_last;
    logic        byte_ready;
    logic        sym_err;
`ifdef MIMO_PACK_STATS_EN
    logic [15:0] byte_cnt;
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0]  nibs [10];
    logic [3:0]  nb;
    logic [7:0]  exp_bytes [32];
    logic [7:0]  first_byte;
    logic [7:0]  last_byte;
    logic [5:0]  pi;
    int          drops;
    int          nbytes;
    int          bad;

    always #5 clk = ~clk;

    mimo_sym_packer #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .demod_1    (demod_1),
        .demod_2    (demod_2),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .sym_err    (sym_err)
`ifdef MIMO_PACK_STATS_EN
        ,
        .byte_cnt   (byte_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] d1, input logic [2:0] d2, input logic last);
        demod_1  = d1;
        demod_2  = d2;
        in_last  = last;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        demod_1  = '0;
        demod_2  = '0;
        in_last  = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        nibs = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
        rst        = 1'b1;
        byte_ready = 1'b0;
        idle();

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", byte_valid, 0);
        chk("rst_data", byte_data, 0);
        chk("rst_last", byte_last, 0);
        chk("rst_sym_err", sym_err, 0);
`ifdef MIMO_PACK_STATS_EN
        chk("rst_byte_cnt", byte_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        rst = 1'b0;
        #1 chk("rel_in_ready", in_ready, 1);

        // (0,1),(3,2 last) -> 8'h1E last
        byte_ready = 1'b1;
        @(negedge clk); drive(3'd0, 3'd1, 1'b0);
        @(negedge clk);
        chk("half_no_push", byte_valid, 0);
        drive(3'd3, 3'd2, 1'b1);
        @(negedge clk);
        idle();
        chk("p1_valid", byte_valid, 1);
        chk("p1_data", byte_data, 16'h1E);
        chk("p1_last", byte_last, 1);
        @(negedge clk);
        chk("p1_drained", byte_valid, 0);

        // Single last pair (2,3) -> 8'hB0; following (1,1) last -> 8'h50 proves EMPTY
        @(negedge clk); drive(3'd2, 3'd3, 1'b1);
        @(negedge clk);
        chk("p2_data", byte_data, 16'hB0);
        chk("p2_last", byte_last, 1);
        drive(3'd1, 3'd1, 1'b1);
        @(negedge clk);
        idle();
        chk("p2b_data", byte_data, 16'h50);
        chk("p2b_last", byte_last, 1);
        @(negedge clk);
        chk("p2_drained", byte_valid, 0);

        // Backpressure: 10 pairs with byte_ready low
        byte_ready = 1'b0;
        drops = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!in_ready) drops++;
            nb = nibs[i];
            drive({1'b0, nb[3:2]}, {1'b0, nb[1:0]}, 1'b0);
        end
        chk("bp_no_early_drop", 16'(drops), 0);
        @(negedge clk);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_head_valid", byte_valid, 1);
        chk("bp_head_data", byte_data, 16'h12);
        nb = nibs[8];
        drive({1'b0, nb[3:2]}, {1'b0, nb[1:0]}, 1'b0);
        @(negedge clk);
        chk("bp_full_ready2", in_ready, 0);
        @(negedge clk);
        chk("bp_full_ready3", in_ready, 0);
        chk("bp_hold_data", byte_data, 16'h12);
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        chk("bp_ready_after_pop", in_ready, 1);
        chk("bp_data2", byte_data, 16'h34);
        @(negedge clk);
        chk("bp_ready_half", in_ready, 1);
        nb = nibs[9];
        drive({1'b0, nb[3:2]}, {1'b0, nb[1:0]}, 1'b1);
        @(negedge clk);
        idle();
        chk("bp_full_again", in_ready, 0);
        chk("bp_data2_hold", byte_data, 16'h34);
        chk("bp_last0", byte_last, 0);
        byte_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_next", in_ready, 1);
        chk("bp_data3", byte_data, 16'h56);
        @(negedge clk);
        chk("bp_data4", byte_data, 16'h78);
        @(negedge clk);
        chk("bp_data5", byte_data, 16'h9A);
        chk("bp_last5", byte_last, 1);
        @(negedge clk);
        chk("bp_drained", byte_valid, 0);
`ifdef MIMO_PACK_STATS_EN
        chk("bp_stall_cnt", stall_cnt, 3);
        chk("bp_byte_cnt", byte_cnt, 8);
`endif

        // Illegal index: (4,0) sets sticky sym_err, data bits give nibble 0
        @(negedge clk);
        chk("se_before", sym_err, 0);
        drive(3'b100, 3'b000, 1'b1);
        @(negedge clk);
        idle();
        chk("se_set", sym_err, 1);
        chk("se_data", byte_data, 16'h00);
        chk("se_valid", byte_valid, 1);
        chk("se_last", byte_last, 1);
        @(negedge clk);
        chk("se_sticky1", sym_err, 1);
        @(negedge clk);
        chk("se_sticky2", sym_err, 1);

        // Mid-frame reset discards queued byte and held nibble
        byte_ready = 1'b0;
        @(negedge clk); drive(3'd3, 3'd3, 1'b1);
        @(negedge clk); drive(3'd3, 3'd3, 1'b0);
        @(negedge clk);
        idle();
        chk("mr_queued", byte_data, 16'hF0);
        #2 rst = 1'b1;
        #1;
        chk("mr_in_ready", in_ready, 0);
        chk("mr_valid", byte_valid, 0);
        chk("mr_data", byte_data, 0);
        chk("mr_sym_err", sym_err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mr_rel_ready", in_ready, 1);
        byte_ready = 1'b1;
        @(negedge clk); drive(3'd1, 3'd1, 1'b0);
        @(negedge clk);
        chk("mr_hold_lost", byte_valid, 0);
        drive(3'd1, 3'd1, 1'b1);
        @(negedge clk);
        idle();
        chk("mr_data55", byte_data, 16'h55);
        chk("mr_last", byte_last, 1);
        @(negedge clk);
        chk("mr_drained", byte_valid, 0);

        // Streaming 64 pairs with byte_ready always high
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            exp_bytes[k] = {6'(2 * k), 6'(2 * k + 1)} == 12'h0 ? 8'h00 : 8'h00;
            pi = 6'(2 * k);
            exp_bytes[k][7:4] = {pi[1:0], pi[3:2]};
            pi = 6'(2 * k + 1);
            exp_bytes[k][3:0] = {pi[1:0], pi[3:2]};
        end
        drops = 0; nbytes = 0; bad = 0;
        first_byte = '0; last_byte = '0;
        for (int c = 0; c < 68; c++) begin
            @(negedge clk);
            if (byte_valid) begin
                if (nbytes < 32) begin
                    if (byte_data !== exp_bytes[nbytes] || byte_last !== (nbytes == 31)) bad++;
                end
                if (nbytes == 0) first_byte = byte_data;
                last_byte = byte_data;
                nbytes++;
            end
            if (c < 64) begin
                if (!in_ready) drops++;
                pi = 6'(c);
                drive({1'b0, pi[1:0]}, {1'b0, pi[3:2]}, c == 63);
            end else begin
                idle();
            end
        end
        chk("st_no_drop", 16'(drops), 0);
        chk("st_nbytes", 16'(nbytes), 32);
        chk("st_bad", 16'(bad), 0);
        chk("st_first", first_byte, 16'h04);
        chk("st_lastbyte", last_byte, 16'hBF);
`ifdef MIMO_PACK_STATS_EN
        chk("st_byte_cnt", byte_cnt, 32);
        chk("st_stall_cnt", stall_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
